// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive controller for the uart_loopback path.
// Synchronises the serial line, detects the start-bit falling edge, enables
// the baud generator (bps_start) for the whole frame and deserialises the
// frame LSB-first on each mid-bit pulse (bps_hf). A good frame updates
// rx_data with a one-cycle rx_valid strobe; a bad stop bit gives a
// one-cycle rx_err strobe instead.
// Optional feature macro: UART_RX_PARITY_EN -- inserts a parity bit between
// the data bits and the stop bit (sense chosen by PARITY_ODD).
module uart_rx_ctrl #(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int PARITY_ODD  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rs232_rx,
   input  logic                 bps_hf,
   output logic                 bps_start,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_err,
   output logic                 rx_busy
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   // Elaboration-time sanity checks on the configuration.
   if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data_bits
      $error("uart_rx_ctrl: DATA_BITS must be in 5..8");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("uart_rx_ctrl: SYNC_STAGES must be at least 2");
   end
   if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity
      $error("uart_rx_ctrl: PARITY_ODD must be 0 or 1");
   end

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd4
   } state_t;
`endif

   state_t                 state_r;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   rx_s;
   logic                   rx_prev_r;
   logic                   fall_s;
   logic [DATA_BITS-1:0]   shift_r;
   logic [CNT_W-1:0]       bit_cnt_r;
   logic                   frame_ok_s;

`ifdef UART_RX_PARITY_EN
   logic                   par_err_r;

   // Expected parity bit for a data word: even parity, inverted for odd.
   function automatic logic parity_calc(input logic [DATA_BITS-1:0] data);
      logic p;
      p = ^data;
      if (PARITY_ODD == 1) begin
         p = ~p;
      end
      return p;
   endfunction
`endif

   // Synchroniser chain on the asynchronous serial line; resets to idle-high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_r    <= {SYNC_STAGES{1'b1}};
         rx_prev_r <= 1'b1;
      end else begin
         sync_r    <= {sync_r[SYNC_STAGES-2:0], rs232_rx};
         rx_prev_r <= rx_s;
      end
   end

   // Synchronised line and its falling-edge detect.
   always_comb begin
      rx_s   = sync_r[SYNC_STAGES-1];
      fall_s = rx_prev_r & ~rx_s;
   end

   // Stop-bit verdict: stop bit high and, with parity, no latched parity error.
   always_comb begin
`ifdef UART_RX_PARITY_EN
      if (rx_s && !par_err_r) begin
         frame_ok_s = 1'b1;
      end else begin
         frame_ok_s = 1'b0;
      end
`else
      if (rx_s) begin
         frame_ok_s = 1'b1;
      end else begin
         frame_ok_s = 1'b0;
      end
`endif
   end

   // Receive FSM with registered outputs; strobes default low every cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         bps_start <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_err    <= 1'b0;
         rx_busy   <= 1'b0;
         shift_r   <= '0;
         bit_cnt_r <= '0;
`ifdef UART_RX_PARITY_EN
         par_err_r <= 1'b0;
`endif
      end else begin
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (fall_s) begin
                  state_r   <= ST_START;
                  bps_start <= 1'b1;
                  rx_busy   <= 1'b1;
               end
            end
            ST_START: begin
               if (bps_hf) begin
                  if (!rx_s) begin
                     state_r   <= ST_DATA;
                     bit_cnt_r <= '0;
`ifdef UART_RX_PARITY_EN
                     par_err_r <= 1'b0;
`endif
                  end else begin
                     // Line was high again at mid start bit: a glitch, not a frame.
                     state_r   <= ST_IDLE;
                     bps_start <= 1'b0;
                     rx_busy   <= 1'b0;
                  end
               end
            end
            ST_DATA: begin
               if (bps_hf) begin
                  shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
                  if (bit_cnt_r == LAST_BIT) begin
                     bit_cnt_r <= '0;
`ifdef UART_RX_PARITY_EN
                     state_r   <= ST_PARITY;
`else
                     state_r   <= ST_STOP;
`endif
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 4'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (bps_hf) begin
                  // A mismatch is only remembered; the verdict is given at STOP.
                  if (rx_s != parity_calc(shift_r)) begin
                     par_err_r <= 1'b1;
                  end
                  state_r <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (bps_hf) begin
                  state_r   <= ST_IDLE;
                  bps_start <= 1'b0;
                  rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                  par_err_r <= 1'b0;
`endif
                  if (frame_ok_s) begin
                     rx_data  <= shift_r;
                     rx_valid <= 1'b1;
                  end else begin
                     rx_err   <= 1'b1;
                  end
               end
            end
            default: begin
               // Unreachable encoding: fall back to a safe idle.
               state_r   <= ST_IDLE;
               bps_start <= 1'b0;
               rx_busy   <= 1'b0;
               bit_cnt_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. A small baud model stands in for
// speed_setting; stimulus pushes expected frames into a queue and a monitor
// on the falling clock edge pops and compares whenever rx_valid/rx_err fires.
module tb_uart_rx_ctrl;

   localparam int BIT = 16;

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rs232_rx = 1'b1;
   logic       bps_hf;
   logic       bps_start;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       rx_busy;

   exp_t exp_q[$];
   int   cmp_cnt = 0;
   int   mis_cnt = 0;
   int   baud_cnt;

   uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2), .PARITY_ODD(0)) dut (
      .clk(clk), .rst(rst), .rs232_rx(rs232_rx), .bps_hf(bps_hf),
      .bps_start(bps_start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_err(rx_err), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   // Baud model: counts while enabled, mid-bit pulse half a period in.
   always @(posedge clk or negedge rst) begin
      if (!rst) baud_cnt <= 0;
      else if (!bps_start) baud_cnt <= 0;
      else if (baud_cnt == BIT - 1) baud_cnt <= 0;
      else baud_cnt <= baud_cnt + 1;
   end
   assign bps_hf = bps_start && (baud_cnt == BIT / 2 - 1);

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst && (rx_valid || rx_err)) begin
         exp_t e;
         cmp_cnt = cmp_cnt + 1;
         if (exp_q.size() == 0) begin
            mis_cnt = mis_cnt + 1;
            $display("FAIL unexpected_strobe: got valid=%0b err=%0b data=%02h, required no output",
                     rx_valid, rx_err, rx_data);
         end else begin
            e = exp_q.pop_front();
            if (rx_valid !== !e.is_err || rx_err !== e.is_err || rx_data !== e.data) begin
               mis_cnt = mis_cnt + 1;
               $display("FAIL frame: got valid=%0b err=%0b data=%02h, required valid=%0b err=%0b data=%02h",
                        rx_valid, rx_err, rx_data, !e.is_err, e.is_err, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      cmp_cnt = cmp_cnt + 1;
      if (act !== req) begin
         mis_cnt = mis_cnt + 1;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic line_bit(input logic b);
      rs232_rx = b;
      repeat (BIT) tick();
   endtask

   // Full frame; optionally checks the bps_start rise timing in the start bit.
   task automatic send_frame(input logic [7:0] d, input logic par_b,
                             input logic stop_b, input bit chk_start);
      rs232_rx = 1'b0;
      for (int i = 0; i < BIT; i++) begin
         tick();
         if (chk_start && i == 1) chk("bps_start_before_3clk", {31'd0, bps_start}, 32'd0);
         if (chk_start && i == 2) begin
            chk("bps_start_at_3clk", {31'd0, bps_start}, 32'd1);
            chk("busy_at_3clk", {31'd0, rx_busy}, 32'd1);
         end
      end
      for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      line_bit(par_b);
`else
      if (par_b === 1'bx) rs232_rx = 1'b1;
`endif
      line_bit(stop_b);
      rs232_rx = 1'b1;
   endtask

   function automatic exp_t ev(input logic is_err, input logic [7:0] d);
      exp_t e;
      e.is_err = is_err;
      e.data   = d;
      return e;
   endfunction

   initial begin
      // Reset state.
      repeat (3) tick();
      chk("reset_bps_start", {31'd0, bps_start}, 32'd0);
      chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
      chk("reset_valid_err", {30'd0, rx_valid, rx_err}, 32'd0);
      chk("reset_busy", {31'd0, rx_busy}, 32'd0);
      rst = 1'b1;
      repeat (2 * BIT) tick();

      // Good frame with bps_start timing check.
      exp_q.push_back(ev(1'b0, 8'hA5));
      send_frame(8'hA5, ^8'hA5, 1'b1, 1'b1);
      repeat (BIT) tick();
      chk("bps_start_after_frame", {31'd0, bps_start}, 32'd0);
      chk("busy_after_frame", {31'd0, rx_busy}, 32'd0);

      // Reset after 4 data bits of 0x3C: partial frame discarded.
      rs232_rx = 1'b0;
      repeat (BIT) tick();
      for (int i = 0; i < 4; i++) line_bit(1'(8'h3C >> i));
      rst = 1'b0;
      rs232_rx = 1'b1;
      tick();
      chk("midreset_rx_data", {24'd0, rx_data}, 32'd0);
      chk("midreset_bps_busy", {30'd0, bps_start, rx_busy}, 32'd0);
      chk("midreset_valid_err", {30'd0, rx_valid, rx_err}, 32'd0);
      repeat (3) tick();
      rst = 1'b1;
      repeat (2 * BIT) tick();
      exp_q.push_back(ev(1'b0, 8'h3C));
      send_frame(8'h3C, ^8'h3C, 1'b1, 1'b0);
      repeat (2 * BIT) tick();

      // Back-to-back frames, one stop bit, no idle gap.
      exp_q.push_back(ev(1'b0, 8'h00));
      exp_q.push_back(ev(1'b0, 8'hFF));
      exp_q.push_back(ev(1'b0, 8'h55));
      send_frame(8'h00, ^8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, ^8'hFF, 1'b1, 1'b0);
      send_frame(8'h55, ^8'h55, 1'b1, 1'b0);
      repeat (2 * BIT) tick();

      // Glitch: short low pulse, START aborts at the first mid-bit pulse.
      begin
         bit seen;
         seen = 1'b0;
         rs232_rx = 1'b0;
         repeat (5) tick();
         rs232_rx = 1'b1;
         for (int i = 0; i < BIT; i++) begin
            tick();
            if (bps_start) seen = 1'b1;
         end
         chk("glitch_bps_pulse_seen", {31'd0, seen}, 32'd1);
         repeat (BIT) tick();
         chk("glitch_back_idle", {30'd0, bps_start, rx_busy}, 32'd0);
      end

      // Framing error keeps previous data; next frame is clean.
      exp_q.push_back(ev(1'b1, 8'h55));
      send_frame(8'h81, ^8'h81, 1'b0, 1'b0);
      repeat (2 * BIT) tick();
      exp_q.push_back(ev(1'b0, 8'h12));
      send_frame(8'h12, ^8'h12, 1'b1, 1'b0);
      repeat (2 * BIT) tick();

      // Break: one rx_err, no restart while the line stays low.
      exp_q.push_back(ev(1'b1, 8'h12));
      rs232_rx = 1'b0;
      repeat (16 * BIT) tick();
      chk("break_no_restart", {30'd0, bps_start, rx_busy}, 32'd0);
      rs232_rx = 1'b1;
      repeat (2 * BIT) tick();

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has odd weight, so parity bit 1 is correct.
      exp_q.push_back(ev(1'b0, 8'h07));
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      repeat (2 * BIT) tick();
      exp_q.push_back(ev(1'b1, 8'h07));
      send_frame(8'h07, 1'b0, 1'b1, 1'b0);
      repeat (2 * BIT) tick();
`endif

      repeat (3 * BIT) tick();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule
